// File: rtl/vec_pkg.sv
// Shared sizes and types for the vec_loader serial-to-vector loader.
// Optional early-completion padding is enabled by defining VLOAD_PAD_EN.
package vec_pkg;

    localparam int VECTOR_SIZE = 16;
    localparam int INT_SIZE    = 16;
    localparam int IDX_W       = $clog2(VECTOR_SIZE);

    typedef logic [INT_SIZE-1:0] elem_t;
    typedef elem_t [VECTOR_SIZE-1:0] vec_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_t;

    function automatic logic is_last_lane(input idx_t idx);
        return (idx == idx_t'(VECTOR_SIZE - 1));
    endfunction

endpackage

// File: rtl/vec_bank.sv
// One storage bank of the loader: per-lane a/x element registers.
// Clear takes priority over write; the controller never requests both at once.
module vec_bank
    import vec_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  wr_en,
    input  idx_t  wr_lane,
    input  elem_t wr_a,
    input  elem_t wr_x,
    input  logic  clr,
    output vec_t  a,
    output vec_t  x
);

    vec_t a_q, a_d;
    vec_t x_q, x_d;

    // Next-state for lane storage: clear whole bank or write one lane.
    always_comb begin
        a_d = a_q;
        x_d = x_q;
        if (clr) begin
            a_d = '0;
            x_d = '0;
        end else if (wr_en) begin
            a_d[wr_lane] = wr_a;
            x_d[wr_lane] = wr_x;
        end else begin
            a_d = a_q;
            x_d = x_q;
        end
    end

    // Lane storage registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            x_q <= '0;
        end else begin
            a_q <= a_d;
            x_q <= x_d;
        end
    end

    assign a = a_q;
    assign x = x_q;

endmodule

// File: rtl/vec_loader.sv
// Double-buffered serial-to-vector loader feeding vmulmax a/x operands.
// Define VLOAD_PAD_EN to let in_last close a vector early (upper lanes read 0).
module vec_loader
    import vec_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  in_valid,
    output logic  in_ready,
    input  elem_t in_a,
    input  elem_t in_x,
    input  logic  in_last,
    output logic  out_valid,
    input  logic  out_ready,
    output vec_t  a,
    output vec_t  x
);

    logic [1:0] full_q, full_d;
    idx_t       wr_idx_q, wr_idx_d;
    bank_t      wr_bank_q, wr_bank_d;
    bank_t      rd_bank_q, rd_bank_d;

    logic accept_s;
    logic take_s;
    logic last_s;
    vec_t bank0_a_s, bank0_x_s, bank1_a_s, bank1_x_s;

    assign in_ready  = ~reset & ~full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign accept_s  = in_valid & in_ready;
    assign take_s    = out_valid & out_ready;

`ifdef VLOAD_PAD_EN
    assign last_s = in_last | is_last_lane(wr_idx_q);
`else
    // in_last has no effect without padding support.
    assign last_s = is_last_lane(wr_idx_q) | (in_last & 1'b0);
`endif

    vec_bank u_bank0 (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (accept_s & (wr_bank_q == BANK0)),
        .wr_lane (wr_idx_q),
        .wr_a    (in_a),
        .wr_x    (in_x),
        .clr     (take_s & (rd_bank_q == BANK0)),
        .a       (bank0_a_s),
        .x       (bank0_x_s)
    );

    vec_bank u_bank1 (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (accept_s & (wr_bank_q == BANK1)),
        .wr_lane (wr_idx_q),
        .wr_a    (in_a),
        .wr_x    (in_x),
        .clr     (take_s & (rd_bank_q == BANK1)),
        .a       (bank1_a_s),
        .x       (bank1_x_s)
    );

    assign a = (rd_bank_q == BANK1) ? bank1_a_s : bank0_a_s;
    assign x = (rd_bank_q == BANK1) ? bank1_x_s : bank0_x_s;

    // Control next-state: a take and a completion touch different banks,
    // since a bank can only be written while it is not full.
    always_comb begin
        full_d    = full_q;
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;

        if (take_s) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = bank_t'(~rd_bank_q);
        end else begin
            rd_bank_d = rd_bank_q;
        end

        if (accept_s) begin
            if (last_s) begin
                full_d[wr_bank_q] = 1'b1;
                wr_idx_d          = '0;
                wr_bank_d         = bank_t'(~wr_bank_q);
            end else begin
                wr_idx_d = wr_idx_q + idx_t'(1);
            end
        end else begin
            wr_idx_d = wr_idx_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q    <= 2'b00;
            wr_idx_q  <= '0;
            wr_bank_q <= BANK0;
            rd_bank_q <= BANK0;
        end else begin
            full_q    <= full_d;
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

endmodule

// File: tb/tb_vec_loader.sv
// Directed self-checking bench for vec_loader: streaming, backpressure, gaps,
// back-to-back vectors, mid-fill reset and in_last handling (VLOAD_PAD_EN aware).
module tb_vec_loader;
    import vec_pkg::*;

    logic  clock = 1'b0;
    logic  reset;
    logic  in_valid;
    logic  in_ready;
    elem_t in_a;
    elem_t in_x;
    logic  in_last;
    logic  out_valid;
    logic  out_ready;
    vec_t  a;
    vec_t  x;

    int n_tests = 0;
    int n_fail  = 0;

    vec_loader dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_x      (in_x),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .x         (x)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_x     = '0;
    endtask

    task automatic test_reset();
        vec_t zero_v;
        zero_v    = '0;
        reset     = 1'b1;
        out_ready = 1'b0;
        idle();
        #3;
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_tests++;
        if (a !== zero_v || x !== zero_v) begin n_fail++; $display("FAIL reset_ax got a=%h x=%h exp 0", a, x); end
        step();
        step();
        reset = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_stream();
        vec_t ea, ex, zero_v;
        int   drops = 0;
        int   premature = 0;
        zero_v    = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_a     = elem_t'(i);
            in_x     = elem_t'(2 * i);
            ea[i]    = elem_t'(i);
            ex[i]    = elem_t'(2 * i);
            if (in_ready !== 1'b1) drops++;
            if (out_valid !== 1'b0) premature++;
            step();
        end
        idle();
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid got %b exp 1", out_valid); end
        n_tests++;
        if (a !== ea) begin n_fail++; $display("FAIL stream_a got %h exp %h", a, ea); end
        n_tests++;
        if (x !== ex) begin n_fail++; $display("FAIL stream_x got %h exp %h", x, ex); end
        n_tests++;
        if (drops !== 0) begin n_fail++; $display("FAIL stream_ready_drops got %0d exp 0", drops); end
        n_tests++;
        if (premature !== 0) begin n_fail++; $display("FAIL stream_premature got %0d exp 0", premature); end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_taken got %b exp 0", out_valid); end
        n_tests++;
        if (a !== zero_v || x !== zero_v) begin n_fail++; $display("FAIL stream_cleared got a=%h x=%h exp 0", a, x); end
    endtask

    task automatic test_backpressure();
        vec_t ea0, ex0, ea1, ex1;
        int   idx = 0;
        logic acc;
        for (int i = 0; i < 16; i++) begin
            ea0[i] = elem_t'(100 + i);
            ex0[i] = elem_t'(16'h1000 + i);
            ea1[i] = elem_t'(116 + i);
            ex1[i] = elem_t'(16'h1010 + i);
        end
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 36; cyc++) begin
            in_valid = 1'b1;
            in_a     = elem_t'(100 + idx);
            in_x     = elem_t'(16'h1000 + idx);
            acc      = in_ready;
            step();
            if (acc) idx++;
        end
        n_tests++;
        if (idx !== 32) begin n_fail++; $display("FAIL bp_accepts got %0d exp 32", idx); end
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        n_tests++;
        if (out_valid !== 1'b1 || a !== ea0 || x !== ex0) begin
            n_fail++; $display("FAIL bp_vec0 got v=%b a=%h exp a=%h", out_valid, a, ea0);
        end
        idle();
        out_ready = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || a !== ea1 || x !== ex1) begin
            n_fail++; $display("FAIL bp_vec1 got v=%b a=%h exp a=%h", out_valid, a, ea1);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_take got %b exp 1", in_ready); end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b exp 0", out_valid); end
    endtask

    task automatic test_gaps();
        vec_t ea, ex;
        int   idx = 0;
        int   premature = 0;
        logic acc;
        for (int i = 0; i < 16; i++) begin
            ea[i] = elem_t'(i);
            ex[i] = elem_t'(2 * i);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 32; cyc++) begin
            in_valid = (cyc % 2 == 1);
            in_a     = elem_t'(idx);
            in_x     = elem_t'(2 * idx);
            acc      = in_valid & in_ready;
            if (out_valid !== 1'b0) premature++;
            step();
            if (acc) idx++;
        end
        idle();
        n_tests++;
        if (premature !== 0) begin n_fail++; $display("FAIL gaps_premature got %0d exp 0", premature); end
        n_tests++;
        if (out_valid !== 1'b1 || a !== ea || x !== ex) begin
            n_fail++; $display("FAIL gaps_vec got v=%b a=%h x=%h exp a=%h x=%h", out_valid, a, x, ea, ex);
        end
        step();
    endtask

    task automatic test_back_to_back();
        vec_t ea, ex;
        int   k = 0;
        int   takes = 0;
        int   bad = 0;
        int   stalls = 0;
        logic acc;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 68; cyc++) begin
            if (k < 64) begin
                in_valid = 1'b1;
                in_a     = elem_t'(1000 + k);
                in_x     = elem_t'(3000 + k);
                if (in_ready !== 1'b1) stalls++;
            end else begin
                idle();
            end
            if (out_valid === 1'b1) begin
                for (int i = 0; i < 16; i++) begin
                    ea[i] = elem_t'(1000 + 16 * takes + i);
                    ex[i] = elem_t'(3000 + 16 * takes + i);
                end
                if (a !== ea || x !== ex) bad++;
                takes++;
            end
            acc = in_valid & in_ready;
            step();
            if (acc) k++;
        end
        idle();
        n_tests++;
        if (k !== 64) begin n_fail++; $display("FAIL b2b_accepts got %0d exp 64", k); end
        n_tests++;
        if (stalls !== 0) begin n_fail++; $display("FAIL b2b_stalls got %0d exp 0", stalls); end
        n_tests++;
        if (takes !== 4) begin n_fail++; $display("FAIL b2b_takes got %0d exp 4", takes); end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL b2b_data got %0d bad vectors exp 0", bad); end
    endtask

    task automatic test_reset_mid();
        vec_t ea, ex, zero_v;
        zero_v    = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_a     = elem_t'(7 + i);
            in_x     = elem_t'(70 + i);
            step();
        end
        idle();
        reset = 1'b1;
        #2;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rmid_flags got rdy=%b v=%b exp 0 0", in_ready, out_valid);
        end
        n_tests++;
        if (a !== zero_v || x !== zero_v) begin n_fail++; $display("FAIL rmid_ax got a=%h x=%h exp 0", a, x); end
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_a     = elem_t'(50 + i);
            in_x     = elem_t'(60 + i);
            ea[i]    = elem_t'(50 + i);
            ex[i]    = elem_t'(60 + i);
            step();
        end
        idle();
        n_tests++;
        if (out_valid !== 1'b1 || a !== ea || x !== ex) begin
            n_fail++; $display("FAIL rmid_vec got v=%b a=%h exp a=%h", out_valid, a, ea);
        end
        step();
    endtask

    task automatic test_last();
        vec_t ea, ex;
        out_ready = 1'b1;
`ifdef VLOAD_PAD_EN
        ea = '0;
        ex = '0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = elem_t'(9);
            in_x     = elem_t'(9);
            in_last  = (i == 4);
            ea[i]    = elem_t'(9);
            ex[i]    = elem_t'(9);
            step();
        end
        idle();
        n_tests++;
        if (out_valid !== 1'b1 || a !== ea || x !== ex) begin
            n_fail++; $display("FAIL last_pad_vec got v=%b a=%h exp a=%h", out_valid, a, ea);
        end
        step();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_a     = elem_t'(20 + i);
            in_x     = elem_t'(40 + i);
            ea[i]    = elem_t'(20 + i);
            ex[i]    = elem_t'(40 + i);
            step();
        end
        idle();
        n_tests++;
        if (out_valid !== 1'b1 || a !== ea || x !== ex) begin
            n_fail++; $display("FAIL last_next_vec got v=%b a=%h exp a=%h", out_valid, a, ea);
        end
        step();
`else
        for (int i = 0; i < 16; i++) begin
            ea[i] = elem_t'(9);
            ex[i] = elem_t'(9);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = elem_t'(9);
            in_x     = elem_t'(9);
            in_last  = (i == 4);
            step();
        end
        idle();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL last_ignored got %b exp 0", out_valid); end
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_a     = elem_t'(9);
            in_x     = elem_t'(9);
            step();
        end
        idle();
        n_tests++;
        if (out_valid !== 1'b1 || a !== ea || x !== ex) begin
            n_fail++; $display("FAIL last_full_vec got v=%b a=%h exp a=%h", out_valid, a, ea);
        end
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_last();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
